am_mod_pipe: RTL

Pipelined, parametrised successor to the combinational standard-AM modulator in the transmitter test path. It computes y = sat((c·2^W + ((2·c·s·k) >>> 8)) >>> 1) for carrier sample c, message sample s and a per-sample runtime modulation index k (unsigned Q8.8). It adds a valid/ready stream interface, a channel tag, output saturation, and overmodulation detection and counting. It feeds the demodulator test benches and DAC packers with full-scale 2W-bit samples.

---
 rtl/am_mod_pipe_pkg.sv | 15 +
 rtl/am_mod_pipe_sat.sv | 26 ++
 rtl/am_mod_pipe.sv | 131 +++++++++++++
 3 files changed

// File: rtl/am_mod_pipe_pkg.sv
// Shared AM modulator types and Q8.8 modulation-index constants.
package pack_me;

  localparam int unsigned K_W    = 16;
  localparam int unsigned K_FRAC = 8;

  typedef logic signed [15:0] sig;
  typedef logic signed [31:0] msig;

  typedef struct packed {
    logic sat;
    logic overmod;
  } am_flags_t;

endpackage

// File: rtl/am_mod_pipe_sat.sv
// Signed IW-bit to OW-bit clamp with a flag set when the value was changed.
module am_sat #(
  parameter int unsigned IW = 51,
  parameter int unsigned OW = 32
) (
  input  logic signed [IW-1:0] din,
  output logic signed [OW-1:0] dout_c,
  output logic                 sat_c
);

  localparam logic signed [IW-1:0] MAX_V = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [IW-1:0] MIN_V = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  always_comb begin
    dout_c = OW'(din);
    sat_c  = 1'b0;
    if (din > MAX_V) begin
      dout_c = OW'(MAX_V);
      sat_c  = 1'b1;
    end else if (din < MIN_V) begin
      dout_c = OW'(MIN_V);
      sat_c  = 1'b1;
    end
  end

endmodule

// File: rtl/am_mod_pipe.sv
// Three-stage standard-AM modulator with valid/ready, channel tag,
// output saturation and overmodulation detection/counting.
module am_mod_pipe
  import pack_me::*;
#(
  parameter int unsigned W  = 16,
  parameter int unsigned CH = 1,
  localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [W-1:0]   carrier_in,
  input  logic signed [W-1:0]   signal_in,
  input  logic [K_W-1:0]        k_in,
  input  logic [CW-1:0]         ch_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [2*W-1:0] signal_out,
  output logic [CW-1:0]         ch_out,
  output logic                  sat_out,
  output logic                  overmod_out,
  input  logic                  clear_count,
  output logic [15:0]           overmod_count
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned QW = W + K_W + 1;
  localparam int unsigned MW = 2 * W + K_W + 2;
  localparam int unsigned TW = MW + 1;

  // Envelope goes negative when k*s drops below -2^(W-1) * 2^K_FRAC
  localparam logic signed [QW-1:0] OM_LIM = {{(QW-W-K_FRAC+1){1'b1}}, {(W+K_FRAC-1){1'b0}}};

  logic                 s1_valid;
  logic signed [PW-1:0] s1_p;
  logic signed [QW-1:0] s1_q;
  logic [K_W-1:0]       s1_k;
  logic signed [W-1:0]  s1_c;
  logic [CW-1:0]        s1_ch;

  logic                 s2_valid;
  logic signed [MW-1:0] s2_m;
  logic                 s2_om;
  logic signed [W-1:0]  s2_c;
  logic [CW-1:0]        s2_ch;

  logic                 s3_valid;
  am_flags_t            s3_flags;

  logic                 en;
  logic signed [PW-1:0] p_c;
  logic signed [QW-1:0] q_c;
  logic signed [MW-1:0] m_c;
  logic                 om_c;
  logic signed [TW-1:0] t_c;
  logic signed [PW-1:0] clamp_c;
  logic                 sat_c;

  assign en       = !s3_valid || out_ready;
  assign in_ready = en;

  assign p_c  = PW'(carrier_in) * PW'(signal_in);
  assign q_c  = QW'($signed({1'b0, k_in})) * QW'(signal_in);
  assign m_c  = ((MW'(s1_p) <<< 1) * MW'($signed({1'b0, s1_k}))) >>> K_FRAC;
  assign om_c = s1_q < OM_LIM;
  assign t_c  = ((TW'(s2_c) <<< W) + TW'(s2_m)) >>> 1;

  am_sat #(
    .IW(TW),
    .OW(PW)
  ) u_sat (
    .din   (t_c),
    .dout_c(clamp_c),
    .sat_c (sat_c)
  );

  assign out_valid   = s3_valid;
  assign sat_out     = s3_flags.sat;
  assign overmod_out = s3_flags.overmod;

  // Pipeline: one global enable, so a stall freezes bubbles too
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_p       <= '0;
      s1_q       <= '0;
      s1_k       <= '0;
      s1_c       <= '0;
      s1_ch      <= '0;
      s2_valid   <= 1'b0;
      s2_m       <= '0;
      s2_om      <= 1'b0;
      s2_c       <= '0;
      s2_ch      <= '0;
      s3_valid   <= 1'b0;
      s3_flags   <= '0;
      signal_out <= '0;
      ch_out     <= '0;
    end else if (en) begin
      s1_valid   <= in_valid;
      s1_p       <= p_c;
      s1_q       <= q_c;
      s1_k       <= k_in;
      s1_c       <= carrier_in;
      s1_ch      <= ch_in;
      s2_valid   <= s1_valid;
      s2_m       <= m_c;
      s2_om      <= om_c;
      s2_c       <= s1_c;
      s2_ch      <= s1_ch;
      s3_valid   <= s2_valid;
      s3_flags   <= '{sat: sat_c, overmod: s2_om};
      signal_out <= clamp_c;
      ch_out     <= s2_ch;
    end
  end

  // Saturating count of transferred overmodulated samples; clear wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overmod_count <= '0;
    end else if (clear_count) begin
      overmod_count <= '0;
    end else if (s3_valid && out_ready && s3_flags.overmod && (overmod_count != 16'hFFFF)) begin
      overmod_count <= overmod_count + 16'd1;
    end
  end

endmodule
